// File: rtl/fifo_sched_pkg.sv
// Shared types and helpers for the FIFO read-port scheduler.
//   state_t    : scheduler FSM states
//   owner_id_t : container for a consumer index (up to MAX_NREQ consumers)
//   onehot()   : consumer index -> one-hot vector, truncated by the caller
package fifo_sched_pkg;

  localparam int unsigned MAX_ID_W = 6;
  localparam int unsigned MAX_NREQ = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef logic [MAX_ID_W-1:0] owner_id_t;

  // One-hot decode of a consumer index.
  function automatic logic [MAX_NREQ-1:0] onehot(input owner_id_t id);
    return MAX_NREQ'(1) << id;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick among read requesters.
// Ports:
//   req       in  NREQ  per-consumer request
//   rr_last   in  ID_W  index of the previous winner
//   winner    out ID_W  first requester found scanning rr_last+1, rr_last+2, ... (mod NREQ)
//   any_valid out 1     at least one request is set
module rr_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] rr_last,
  output logic [ID_W-1:0] winner,
  output logic            any_valid
);

  // Scan starts one past the last winner so the previous owner has lowest priority.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    winner    = '0;
    any_valid = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = (32'(rr_last) + i) % NREQ;
      if (!any_valid && req[ID_W'(idx)]) begin
        winner    = ID_W'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_read_sched.sv
// Read-side scheduler for a shared FIFO read port: round-robin grants with bounded
// bursts, drives the read enable and routes returned RAM data to its consumer.
// Ports:
//   CLK        in  1       clock, rising edge
//   RST        in  1       asynchronous active-high reset
//   REQ        in  NREQ    per-consumer level request
//   EMPTY_FLAG in  1       FIFO empty
//   RD_DATA    in  DATA_W  RAM data, valid the cycle after INC
//   INC        out 1       read enable (combinational from state and inputs)
//   GNT        out NREQ    one-hot current owner, 0 when idle
//   DOUT       out DATA_W  registered read data
//   DVALID     out NREQ    one-hot DOUT qualifier, one cycle per word
module fifo_read_sched
  import fifo_sched_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [NREQ-1:0]   REQ,
  input  logic              EMPTY_FLAG,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              INC,
  output logic [NREQ-1:0]   GNT,
  output logic [DATA_W-1:0] DOUT,
  output logic [NREQ-1:0]   DVALID
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

  state_t            state;
  logic [ID_W-1:0]   owner;
  logic [ID_W-1:0]   rr_last;
  logic [CNT_W-1:0]  cnt;
  logic [ID_W-1:0]   winner;
  logic              any_valid;
  logic              owner_req;
  logic              last_read;
  logic              rd_v;
  logic [ID_W-1:0]   rd_owner;

  rr_arbiter #(
    .NREQ (NREQ),
    .ID_W (ID_W)
  ) u_arb (
    .req       (REQ),
    .rr_last   (rr_last),
    .winner    (winner),
    .any_valid (any_valid)
  );

  assign owner_req = REQ[owner];
  assign last_read = (cnt == CNT_W'(MAX_BURST - 1));

  // Read only for a live owner with data available and burst budget left.
  assign INC = (state == BURST) && owner_req && !EMPTY_FLAG && (cnt < CNT_W'(MAX_BURST));

  // Grant FSM: every burst ends in IDLE, so re-arbitration costs one bubble cycle.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      GNT     <= '0;
      owner   <= '0;
      cnt     <= '0;
      rr_last <= ID_W'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (any_valid && !EMPTY_FLAG) begin
            state   <= BURST;
            owner   <= winner;
            rr_last <= winner;
            GNT     <= NREQ'(onehot(owner_id_t'(winner)));
            cnt     <= '0;
          end
        end
        BURST: begin
          if (INC) begin
            cnt <= cnt + CNT_W'(1);
          end
          if ((INC && last_read) || !owner_req || EMPTY_FLAG) begin
            state <= IDLE;
            GNT   <= '0;
          end
        end
        default: begin
          state <= IDLE;
          GNT   <= '0;
        end
      endcase
    end
  end

  // Return path: the owner id travels with each read so words in flight still
  // reach their consumer after the grant moves on.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rd_v     <= 1'b0;
      rd_owner <= '0;
      DOUT     <= '0;
      DVALID   <= '0;
    end else begin
      rd_v     <= INC;
      rd_owner <= owner;
      DVALID   <= rd_v ? NREQ'(onehot(owner_id_t'(rd_owner))) : '0;
      if (rd_v) begin
        DOUT <= RD_DATA;
      end
    end
  end

endmodule
